// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant counters (gnt_cnt0_o/gnt_cnt1_o) are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*WIDTH-1:0]    req_op1_i,
    input  logic [2*WIDTH-1:0]    req_op2_i,
    input  logic [2*FUNC_W-1:0]   req_func_i,
    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_result_o,
    output logic [3:0]            rsp_flags_o,
    output logic [WIDTH-1:0]      alu_op1_o,
    output logic [WIDTH-1:0]      alu_op2_o,
    output logic [FUNC_W-1:0]     alu_func_o,
    input  logic [WIDTH-1:0]      alu_result_i,
    input  logic [3:0]            alu_flags_i
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]           gnt_cnt0_o,
    output logic [15:0]           gnt_cnt1_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [WIDTH-1:0]  r_op1;
    logic [WIDTH-1:0]  r_op2;
    logic [FUNC_W-1:0] r_func;
    logic [WIDTH-1:0]  r_result;
    logic [3:0]        r_flags;

    logic              w_gnt;
    logic              w_gnt_id;
    logic              w_rsp_done;
    logic [WIDTH-1:0]  w_sel_op1;
    logic [WIDTH-1:0]  w_sel_op2;
    logic [FUNC_W-1:0] w_sel_func;

    // Contention goes to the port that did not own the previous completed op.
    assign w_gnt_id   = (&req_valid_i) ? ~r_last_owner : req_valid_i[1];
    assign w_gnt      = rst_n && (r_state == S_IDLE) && (|req_valid_i);
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready_i[r_owner];

    assign w_sel_op1  = w_gnt_id ? req_op1_i[WIDTH +: WIDTH]   : req_op1_i[0 +: WIDTH];
    assign w_sel_op2  = w_gnt_id ? req_op2_i[WIDTH +: WIDTH]   : req_op2_i[0 +: WIDTH];
    assign w_sel_func = w_gnt_id ? req_func_i[FUNC_W +: FUNC_W] : req_func_i[0 +: FUNC_W];

    assign req_ready_o  = w_gnt ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid_o  = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result_o = r_result;
    assign rsp_flags_o  = r_flags;
    assign alu_op1_o    = r_op1;
    assign alu_op2_o    = r_op2;
    assign alu_func_o   = r_func;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_state <= S_EXEC;
                        r_owner <= w_gnt_id;
                    end
                end
                S_EXEC: r_state <= S_RESP;
                S_RESP: begin
                    if (w_rsp_done) begin
                        r_state      <= S_IDLE;
                        r_last_owner <= r_owner;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operands are latched at grant and stay on the ALU bus until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_func <= '0;
        end else if (w_gnt) begin
            r_op1  <= w_sel_op1;
            r_op2  <= w_sel_op2;
            r_func <= w_sel_func;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (r_state == S_EXEC) begin
            r_result <= alu_result_i;
            r_flags  <= alu_flags_i;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_gnt_cnt0;
    logic [15:0] r_gnt_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else if (w_gnt) begin
            if (!w_gnt_id && (r_gnt_cnt0 != 16'hFFFF)) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
            if (w_gnt_id && (r_gnt_cnt1 != 16'hFFFF))  r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
        end
    end

    assign gnt_cnt0_o = r_gnt_cnt0;
    assign gnt_cnt1_o = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU closes the loop, a request-level
// model predicts grants and responses, and a monitor checks every presented response.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid_i = '0;
    logic [1:0]      req_ready_o;
    logic [2*W-1:0]  req_op1_i = '0;
    logic [2*W-1:0]  req_op2_i = '0;
    logic [2*FW-1:0] req_func_i = '0;
    logic [1:0]      rsp_valid_o;
    logic [1:0]      rsp_ready_i = 2'b11;
    logic [W-1:0]    rsp_result_o;
    logic [3:0]      rsp_flags_o;
    logic [W-1:0]    alu_op1_o;
    logic [W-1:0]    alu_op2_o;
    logic [FW-1:0]   alu_func_o;
    logic [W-1:0]    alu_result_i;
    logic [3:0]      alu_flags_i;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]     gnt_cnt0_o;
    logic [15:0]     gnt_cnt1_o;
`endif

    alu_arbiter #(.WIDTH(W), .FUNC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_func_i(req_func_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
        .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_func_o(alu_func_o),
        .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i)
`ifdef ALU_ARB_STATS_EN
        , .gnt_cnt0_o(gnt_cnt0_o), .gnt_cnt1_o(gnt_cnt1_o)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, zero, equals, above, result}.
    function automatic logic [W+3:0] alu_f(input logic [FW-1:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ovf;
        ovf = 1'b0;
        case (f)
            4'd1: begin r = a + b; ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: begin r = a - b; ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            default: r = a ^ b;
        endcase
        return {ovf, (r == '0), (a == b), (a > b), r};
    endfunction

    assign {alu_flags_i, alu_result_i} = alu_f(alu_func_o, alu_op1_o, alu_op2_o);

    typedef struct {
        int           port;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_cnt0 = 0;
    int   m_cnt1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a granted op answers two cycles later and holds until its port accepts.
    initial begin : model
        int   phase;
        int   owner;
        int   last;
        int   g;
        logic [W+3:0] r;
        phase = 0; owner = 0; last = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0; last = 1; m_cnt0 = 0; m_cnt1 = 0;
                sb_q.delete();
                check("rst_req_ready", 64'(req_ready_o), 64'd0);
                check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
                check("rst_result", 64'(rsp_result_o), 64'd0);
                check("rst_flags", 64'(rsp_flags_o), 64'd0);
                check("rst_alu_bus", {alu_op1_o, alu_op2_o[27:0], alu_func_o}, 64'd0);
            end else if (phase == 0) begin
                check("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
                if (req_valid_i != 2'b00) begin
                    g = (req_valid_i == 2'b11) ? 1 - last : (req_valid_i[1] ? 1 : 0);
                    check("grant", 64'(req_ready_o), 64'(1 << g));
                    r = alu_f(req_func_i[g*FW +: FW], req_op1_i[g*W +: W], req_op2_i[g*W +: W]);
                    sb_q.push_back('{port: g, res: r[W-1:0], flg: r[W+3:W]});
                    if (g == 0) m_cnt0++; else m_cnt1++;
                    owner = g;
                    phase = 1;
                end else begin
                    check("idle_no_grant", 64'(req_ready_o), 64'd0);
                end
            end else if (phase == 1) begin
                check("exec_req_ready", 64'(req_ready_o), 64'd0);
                check("exec_rsp_valid", 64'(rsp_valid_o), 64'd0);
                phase = 2;
            end else begin
                check("resp_req_ready", 64'(req_ready_o), 64'd0);
                check("resp_valid", 64'(rsp_valid_o), 64'(1 << owner));
                if (rsp_ready_i[owner]) begin
                    last  = owner;
                    phase = 0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid_o != 2'b00) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid %b, expected no response", rsp_valid_o);
                end else begin
                    e = sb_q[0];
                    check("rsp_port", 64'(rsp_valid_o), 64'(1 << e.port));
                    check("rsp_result", 64'(rsp_result_o), 64'(e.res));
                    check("rsp_flags", 64'(rsp_flags_o), 64'(e.flg));
                    if (rsp_valid_o[e.port] && rsp_ready_i[e.port]) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic set_port(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [FW-1:0] f);
        req_op1_i[p*W +: W]   = a;
        req_op2_i[p*W +: W]   = b;
        req_func_i[p*FW +: FW] = f;
    endtask

    // Holds one request until it is accepted, then drops it after the accepting edge.
    task automatic drive_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [FW-1:0] f);
        bit ok;
        ok = 1'b0;
        set_port(p, a, b, f);
        req_valid_i[p] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready_o[p]) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: port %0d not accepted, expected accept within 50 cycles", p);
        end
        @(posedge clk); #1;
        req_valid_i[p] = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit ok;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Contention straight out of reset: port 0, then strict alternation.
        rsp_ready_i = 2'b11;
        req_valid_i = 2'b11;
        for (int i = 0; i < 12; i++) begin
            set_port(0, $urandom, $urandom, 4'(1 + (i % 4)));
            set_port(1, $urandom, $urandom, 4'(1 + ((i + 1) % 4)));
            @(posedge clk); #1;
        end
        req_valid_i = 2'b00;
        wait_idle();

        drive_req(0, 32'd5, 32'd7, 4'd1);
        wait_idle();
        drive_req(1, 32'h7FFF_FFFF, 32'd1, 4'd1);
        wait_idle();
        drive_req(1, -32'sd5, 32'd5, 4'd1);
        wait_idle();
        drive_req(0, 32'h8000_0000, 32'd1, 4'd2);
        wait_idle();

        // Response stall with a competing request pending.
        rsp_ready_i = 2'b00;
        drive_req(0, 32'd100, 32'd23, 4'd2);
        set_port(1, 32'hDEAD_0000, 32'h0000_BEEF, 4'd4);
        req_valid_i[1] = 1'b1;
        repeat (7) @(posedge clk);
        #1 rsp_ready_i = 2'b10;
        repeat (2) @(posedge clk);
        #1 rsp_ready_i = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready_o[1]) ok = 1'b1;
        end
        check("stall_then_grant1", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 2'b00;
        wait_idle();

        // Reset pulse while an op is in EXEC; contention afterwards restarts at port 0.
        drive_req(1, 32'd9, 32'd9, 4'd2);
        #1 rst_n = 1'b0;
        #1 check("rst_async_rsp_valid", 64'(rsp_valid_o), 64'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 2'b11;
        set_port(0, 32'd1, 32'd2, 4'd1);
        set_port(1, 32'd3, 32'd4, 4'd1);
        repeat (6) @(posedge clk);
        #1 req_valid_i = 2'b00;
        wait_idle();

        // Randomised traffic with random response back-pressure.
        for (int i = 0; i < 400; i++) begin
            req_valid_i = 2'($urandom_range(0, 3));
            rsp_ready_i = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0)
                    set_port(p, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                             4'($urandom_range(0, 5)));
                else
                    set_port(p, $urandom, $urandom, 4'($urandom_range(0, 5)));
            end
            @(posedge clk); #1;
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        repeat (6) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
`ifdef ALU_ARB_STATS_EN
        check("gnt_cnt0", 64'(gnt_cnt0_o), 64'(m_cnt0));
        check("gnt_cnt1", 64'(gnt_cnt1_o), 64'(m_cnt1));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
